// File: rtl/pio_bank_pkg.sv
// pio_bank_pkg: shared definitions for the parallel I/O bank.
//   - Register offsets within a channel's 8-word window.
//   - Edge capture mode encodings.
//   - addr_width(): word-address width for a given channel count.
package pio_bank_pkg;

  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_MASK = 3'd2;
  localparam logic [2:0] OFF_EDGE = 3'd3;
  localparam logic [2:0] OFF_SET  = 3'd4;
  localparam logic [2:0] OFF_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Channel index in the upper bits, 3-bit register offset in the lower bits.
  function automatic int addr_width(input int num_ch);
    return $clog2(num_ch) + 3;
  endfunction

endpackage

// File: rtl/pio_bank_chan.sv
// pio_bank_chan: one channel of the PIO bank.
//   clk, rst_n   : clock, asynchronous active-low reset
//   edge_en      : edge detection enable (high once the synchroniser is primed)
//   wr_en        : write strobe already decoded for this channel
//   wr_off       : register offset of the write
//   wr_data      : write data (low WIDTH bits)
//   pin          : asynchronous input bits
//   out_reg      : OUT register (drives the pins)
//   in_sync      : synchronised input value
//   mask_reg     : IRQ_MASK register
//   edge_reg     : EDGE_CAP register
//   irq_req      : channel interrupt request, |(EDGE_CAP & IRQ_MASK)
module pio_bank_chan
  import pio_bank_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          EDGE_MODE   = 0,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_en,
  input  logic             wr_en,
  input  logic [2:0]       wr_off,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] out_reg,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] mask_reg,
  output logic [WIDTH-1:0] edge_reg,
  output logic             irq_req
);

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] w1c_bits;

  assign in_sync = sync_reg[SYNC_STAGES-1];

  // prev_reg keeps tracking the synchronised value while detection is
  // disabled, so it already matches the input when detection turns on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      prev_reg <= in_sync;
    end
  end

  always_comb begin
    if (EDGE_MODE == EDGE_FALL)     edge_raw = prev_reg & ~in_sync;
    else if (EDGE_MODE == EDGE_ANY) edge_raw = prev_reg ^ in_sync;
    else                            edge_raw = in_sync & ~prev_reg;
    edge_det = edge_en ? edge_raw : '0;
  end

  always_comb begin
    out_next  = out_reg;
    mask_next = mask_reg;
    w1c_bits  = '0;
    if (wr_en) begin
      case (wr_off)
        OFF_OUT:  out_next  = wr_data;
        OFF_MASK: mask_next = wr_data;
        OFF_EDGE: w1c_bits  = wr_data;
        OFF_SET:  out_next  = out_reg | wr_data;
        OFF_CLR:  out_next  = out_reg & ~wr_data;
        default:  ;
      endcase
    end
    // A fresh edge is ORed in after the clear so it survives a colliding W1C.
    edge_next = (edge_reg & ~w1c_bits) | edge_det;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= OUT_RESET[WIDTH-1:0];
      mask_reg <= '0;
      edge_reg <= '0;
    end else begin
      out_reg  <= out_next;
      mask_reg <= mask_next;
      edge_reg <= edge_next;
    end
  end

  assign irq_req = |(edge_reg & mask_reg);

endmodule

// File: rtl/pio_bank_mm.sv
// pio_bank_mm: multi-channel Avalon-MM parallel I/O bank.
//   clk_clk        : system clock
//   reset_reset_n  : asynchronous active-low reset
//   avs_address    : {channel, offset[2:0]} word address
//   avs_read/write : bus strobes, no wait states
//   avs_writedata  : write data
//   avs_readdata   : registered read data, latency 1, held while idle
//   pio_in         : asynchronous inputs, channel c at [c*WIDTH +: WIDTH]
//   pio_out        : output registers, same packing
//   irq            : registered OR of all masked edge captures
module pio_bank_mm
  import pio_bank_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          WIDTH       = 16,
  parameter int          EDGE_MODE   = 0,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter int          SYNC_STAGES = 2,
  localparam int         AW          = addr_width(NUM_CH)
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [AW-1:0]           avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  input  logic [NUM_CH*WIDTH-1:0] pio_in,
  output logic [NUM_CH*WIDTH-1:0] pio_out,
  output logic                    irq
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [AW-1:0]    chan_sel;
  logic [2:0]       reg_off;
  logic [2:0]       prime_reg;
  logic             edge_en;
  logic [31:0]      rd_next;
  logic [NUM_CH-1:0] irq_req_vec;
  logic [WIDTH-1:0] out_vec  [NUM_CH];
  logic [WIDTH-1:0] in_vec   [NUM_CH];
  logic [WIDTH-1:0] mask_vec [NUM_CH];
  logic [WIDTH-1:0] edge_vec [NUM_CH];

  // Write data above WIDTH is discarded by design.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Shift rather than slice so a single-channel bank (no channel bits) works;
  // any nonzero upper bits then simply select no channel.
  assign chan_sel = avs_address >> 3;
  assign reg_off  = avs_address[2:0];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    pio_bank_chan #(
      .WIDTH      (WIDTH),
      .EDGE_MODE  (EDGE_MODE),
      .OUT_RESET  (OUT_RESET),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .edge_en (edge_en),
      .wr_en   (avs_write && (chan_sel == AW'(gi))),
      .wr_off  (reg_off),
      .wr_data (avs_writedata[WIDTH-1:0]),
      .pin     (pio_in[gi*WIDTH +: WIDTH]),
      .out_reg (out_vec[gi]),
      .in_sync (in_vec[gi]),
      .mask_reg(mask_vec[gi]),
      .edge_reg(edge_vec[gi]),
      .irq_req (irq_req_vec[gi])
    );
    assign pio_out[gi*WIDTH +: WIDTH] = out_vec[gi];
  end

  // Counts the synchroniser fill plus the previous-value load; edges are
  // ignored until then so inputs already active at release are not captured.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) prime_reg <= '0;
    else if (prime_reg != PRIME_MAX) prime_reg <= prime_reg + 3'd1;
  end
  assign edge_en = (prime_reg == PRIME_MAX);

  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan_sel == AW'(c)) begin
        case (reg_off)
          OFF_OUT:  rd_next[WIDTH-1:0] = out_vec[c];
          OFF_IN:   rd_next[WIDTH-1:0] = in_vec[c];
          OFF_MASK: rd_next[WIDTH-1:0] = mask_vec[c];
          OFF_EDGE: rd_next[WIDTH-1:0] = edge_vec[c];
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (avs_read) avs_readdata <= rd_next;
      irq <= |irq_req_vec;
    end
  end

endmodule

// File: tb/tb_pio_bank_mm.sv
// Testbench for pio_bank_mm: two instances (rising and any-edge capture)
// share one bus and one set of inputs; a register-level model predicts
// every readback, pin value and interrupt.
module tb_pio_bank_mm;

  localparam int NCH = 5;
  localparam int W   = 16;
  localparam int SS  = 2;
  localparam int AW  = $clog2(NCH) + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [NCH*W-1:0]  pio_in = '1;
  logic [31:0]       rd0, rd2;
  logic [NCH*W-1:0]  out0, out2;
  logic              irq0, irq2;

  int errors = 0;
  int checks = 0;

  // Model state; index k: 0 = rising-edge instance, 1 = any-edge instance.
  logic [W-1:0] m_out  [NCH];
  logic [W-1:0] m_mask [NCH];
  logic [W-1:0] m_in   [NCH];
  logic [W-1:0] m_cap  [2][NCH];

  always #5 clk = ~clk;

  pio_bank_mm #(.NUM_CH(NCH), .WIDTH(W), .EDGE_MODE(0), .OUT_RESET(32'h00FF), .SYNC_STAGES(SS)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd0),
    .pio_in(pio_in), .pio_out(out0), .irq(irq0));

  pio_bank_mm #(.NUM_CH(NCH), .WIDTH(W), .EDGE_MODE(2), .OUT_RESET(32'h00FF), .SYNC_STAGES(SS)) dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd2),
    .pio_in(pio_in), .pio_out(out2), .irq(irq2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_out[c] = 16'h00FF; m_mask[c] = '0; m_cap[0][c] = '0; m_cap[1][c] = '0;
    end
  endfunction

  function automatic void model_write(input int ch, input int off, input logic [31:0] d);
    if (ch >= NCH) return;
    case (off)
      0: m_out[ch] = d[W-1:0];
      2: m_mask[ch] = d[W-1:0];
      3: begin m_cap[0][ch] &= ~d[W-1:0]; m_cap[1][ch] &= ~d[W-1:0]; end
      4: m_out[ch] |= d[W-1:0];
      5: m_out[ch] &= ~d[W-1:0];
      default: ;
    endcase
  endfunction

  // Edge rule: rising instance captures 0->1 bits, any-edge captures changed bits.
  function automatic void model_edge(input int ch, input logic [W-1:0] v);
    m_cap[0][ch] |= v & ~m_in[ch];
    m_cap[1][ch] |= v ^ m_in[ch];
    m_in[ch] = v;
  endfunction

  function automatic logic [31:0] exp_reg(input int k, input int ch, input int off);
    if (ch >= NCH) return 32'h0;
    case (off)
      0: return 32'(m_out[ch]);
      1: return 32'(m_in[ch]);
      2: return 32'(m_mask[ch]);
      3: return 32'(m_cap[k][ch]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_irq(input int k);
    for (int c = 0; c < NCH; c++) if ((m_cap[k][c] & m_mask[c]) != '0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic bus_write(input int ch, input int off, input logic [31:0] d);
    avs_address = AW'((ch << 3) | off);
    avs_writedata = d;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
    model_write(ch, off, d);
    $display("WR ch%0d off%0d data=%h", ch, off, d);
  endtask

  task automatic bus_read(input int ch, input int off);
    avs_address = AW'((ch << 3) | off);
    avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    $display("RD ch%0d off%0d rd0=%h rd2=%h", ch, off, rd0, rd2);
    check($sformatf("rd0 ch%0d off%0d", ch, off), rd0, exp_reg(0, ch, off));
    check($sformatf("rd2 ch%0d off%0d", ch, off), rd2, exp_reg(1, ch, off));
  endtask

  task automatic drive_in(input int ch, input logic [W-1:0] v);
    pio_in[ch*W +: W] = v;
  endtask

  task automatic set_input(input int ch, input logic [W-1:0] v);
    drive_in(ch, v);
    model_edge(ch, v);
    tick(SS + 3);
    $display("IN ch%0d <= %h", ch, v);
  endtask

  task automatic check_pins(input string tag);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("%s out0 ch%0d", tag, c), 32'(out0[c*W +: W]), 32'(m_out[c]));
      check($sformatf("%s out2 ch%0d", tag, c), 32'(out2[c*W +: W]), 32'(m_out[c]));
    end
  endtask

  task automatic check_irq(input string tag);
    check({tag, " irq0"}, 32'(irq0), 32'(exp_irq(0)));
    check({tag, " irq2"}, 32'(irq2), 32'(exp_irq(1)));
  endtask

  task automatic clear_all();
    for (int c = 0; c < NCH; c++) begin
      bus_write(c, 2, 32'h0);
      bus_write(c, 3, 32'hFFFF_FFFF);
    end
    tick(2);
  endtask

  initial begin
    logic [31:0] held0, held2;
    // ---- Reset with inputs already high ----
    model_reset();
    for (int c = 0; c < NCH; c++) m_in[c] = '1;
    tick(3);
    check("reset rd0", rd0, 32'h0);
    check("reset rd2", rd2, 32'h0);
    check_irq("reset");
    check_pins("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_irq($sformatf("post-release cyc%0d", i));
    end
    for (int c = 0; c < NCH; c++) bus_read(c, 3);
    for (int c = 0; c < NCH; c++) bus_read(c, 0);

    // ---- Drop all inputs, then clear captures ----
    for (int c = 0; c < NCH; c++) set_input(c, 16'h0000);
    clear_all();

    // ---- Set / clear on channel 2 ----
    bus_write(2, 0, 32'h0000_1234);
    bus_write(2, 4, 32'h0000_000F);
    bus_write(2, 5, 32'h0000_1000);
    tick();
    check_pins("setclr");
    check("setclr model", 32'(m_out[2]), 32'h0000_023F);
    bus_read(2, 0);

    // ---- Rising edge on ch1 bit0 with interrupt latency ----
    bus_write(1, 2, 32'h0000_0001);
    tick(2);
    drive_in(1, 16'h0001);
    model_edge(1, 16'h0001);
    tick(SS + 1);
    check("edge lat irq0 early", 32'(irq0), 32'h0);
    check("edge lat irq2 early", 32'(irq2), 32'h0);
    tick();
    check("edge lat irq0", 32'(irq0), 32'h1);
    check("edge lat irq2", 32'(irq2), 32'h1);
    bus_read(1, 3);
    bus_write(1, 3, 32'h0000_0001);
    tick();
    check_irq("w1c drop");
    set_input(1, 16'h0000);
    bus_read(1, 3);
    check_irq("falling");
    bus_write(1, 2, 32'h0);
    clear_all();

    // ---- W1C collides with new edge on ch0 bit3 ----
    set_input(0, 16'h0028);
    set_input(0, 16'h0020);
    drive_in(0, 16'h0028);
    tick(SS);
    avs_address = AW'(3);
    avs_writedata = 32'h0000_0008;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
    model_write(0, 3, 32'h0000_0008);
    model_edge(0, 16'h0028);
    $display("WR ch0 off3 data=00000008 (collision)");
    tick(3);
    bus_read(0, 3);
    bus_write(0, 3, 32'h0000_0020);
    bus_read(0, 3);
    clear_all();

    // ---- Randomised traffic ----
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: bus_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom);
        1: bus_read($urandom_range(0, 7), $urandom_range(0, 7));
        2: set_input($urandom_range(0, NCH-1), 16'($urandom));
        3: bus_write($urandom_range(0, NCH-1), 2, $urandom);
        default: begin tick(2); check_pins("rand"); check_irq("rand"); end
      endcase
    end
    tick(2);
    check_irq("rand end");
    clear_all();

    // ---- Unmapped offsets and channels ----
    bus_read(0, 6);
    bus_read(NCH, 0);
    bus_read(0, 4);
    bus_write(0, 6, 32'hFFFF_FFFF);
    bus_write(0, 7, 32'hFFFF_FFFF);
    for (int o = 0; o < 6; o++) bus_write(NCH, o, 32'hFFFF_FFFF);
    bus_write(7, 0, 32'hFFFF_FFFF);
    tick();
    check_pins("unmapped");
    for (int c = 0; c < NCH; c++) begin
      bus_read(c, 0);
      bus_read(c, 2);
      bus_read(c, 3);
    end
    set_input(3, 16'hA5A5);
    bus_read(3, 1);
    held0 = exp_reg(0, 3, 1);
    held2 = exp_reg(1, 3, 1);
    tick(3);
    check("hold rd0", rd0, held0);
    check("hold rd2", rd2, held2);

    // ---- Edge sequence 0000 -> 0101 -> 0001 on ch0, masks off ----
    clear_all();
    set_input(0, 16'h0000);
    clear_all();
    set_input(0, 16'h0101);
    set_input(0, 16'h0001);
    bus_read(0, 3);
    check("anyedge model", 32'(m_cap[1][0]), 32'h0101);
    tick(2);
    check_irq("masked off");

    // ---- Reset mid-operation ----
    bus_write(0, 0, 32'h0000_BEEF);
    bus_read(0, 0);
    avs_read = 1'b1;
    rst_n = 1'b0;
    #1;
    avs_read = 1'b0;
    model_reset();
    check("midreset rd0", rd0, 32'h0);
    check("midreset rd2", rd2, 32'h0);
    check_pins("midreset");
    check_irq("midreset");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_bank_mm.md
Name: pio_bank_mm

Overview:
Parametrised multi-channel Avalon-MM parallel I/O bank that replaces the separate fixed-width PIO exports (keys, buttons, hex digits, LEDs, keycode, display coordinates) in the mnist_nn system. It provides:
- NUM_CH channels, each with a WIDTH-bit output register and a synchronised WIDTH-bit input.
- Per-channel edge capture, interrupt masking and atomic set/clear of output bits.
- A single combined interrupt line to the Nios II.

Parameters:
NUM_CH, 4, number of channels (1..16)
WIDTH, 16, bits per channel (1..32)
EDGE_MODE, 0, edge capture type: 0 rising, 1 falling, 2 any
OUT_RESET, 0, reset value loaded into every channel output register (low WIDTH bits used)
SYNC_STAGES, 2, input synchroniser depth (2..4)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  clog2(NUM_CH)+3  word address: channel = upper bits, register offset = low 3 bits
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
pio_in  in  NUM_CH*WIDTH  asynchronous inputs; channel c occupies bits [c*WIDTH +: WIDTH]
pio_out  out  NUM_CH*WIDTH  output registers, same packing as pio_in
irq  out  1  combined interrupt, registered, active high

Behaviour:
- Clocking and reset: one clock, clk_clk. reset_reset_n is asynchronous assert, synchronous release, active low.
- Reset values:
  - pio_out = OUT_RESET on every channel.
  - Masks, edge-capture registers, synchroniser flops and previous-value register = 0.
  - avs_readdata = 0, irq = 0.
  - Prime counter = 0.
- Register map per channel (offset):
  - 0 OUT: read/write.
  - 1 IN: read-only, synchronised value.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read; write-1-to-clear.
  - 4 OUTSET: write-only; OUT |= wdata. Reads 0.
  - 5 OUTCLR: write-only; OUT &= ~wdata. Reads 0.
  - 6, 7: reserved.
- Unmapped accesses:
  - Reserved offsets, and channel index >= NUM_CH, read 0; writes to them are ignored.
  - Bits [31:WIDTH] always read 0; written values there are discarded.
- Read path:
  - Fixed read latency 1: avs_readdata is valid the cycle after avs_read.
  - avs_readdata holds its value when avs_read is low.
  - No wait states; reads have no side effects.
- Write timing: takes effect at the clock edge where avs_write = 1. The new OUT value appears on pio_out the next cycle.
- Synchroniser and prime counter:
  - Each input bit passes through SYNC_STAGES flops to give the synchronised value; IN returns this value.
  - A prime counter counts from 0 to SYNC_STAGES+1 after reset release, then saturates.
  - Edge detection is enabled only once the counter has saturated. This prevents spurious edges from inputs that are already active at reset release.
- Edge detection:
  - Compares the synchronised value with the registered previous value.
  - Detected edge bits OR into EDGE_CAP.
  - Edge-to-EDGE_CAP latency is SYNC_STAGES+1 cycles from the input change.
- Simultaneous events:
  - A W1C write to EDGE_CAP in the same cycle as a new edge on the same bit leaves the bit set (set wins).
  - Other bits clear normally.
- Interrupt:
  - irq_next = OR over all channels of (EDGE_CAP & IRQ_MASK); irq is irq_next registered (1 cycle).
  - Clearing the mask or the capture bit drops irq on the next cycle.
- Reset mid-operation: all state returns to reset values immediately. An outstanding read returns 0 and the prime counter restarts.

Decomposition:
- Shared package pio_bank_pkg holds:
  - Register offset constants: OFF_OUT=0, OFF_IN=1, OFF_MASK=2, OFF_EDGE=3, OFF_SET=4, OFF_CLR=5.
  - Edge mode constants.
  - A function computing address width from NUM_CH.
- One sub-module, pio_bank_chan, generated NUM_CH times. It contains:
  - The synchroniser, edge detector, OUT/MASK/EDGE_CAP registers and per-channel interrupt request.
- The top level keeps:
  - Address decode, the readdata mux/register, the prime counter and the irq OR-reduction.

Test Plan:
- Reset: set OUT_RESET=16'h00FF, assert reset_reset_n=0 with pio_in=all 1s, then release -> pio_out=16'h00FF on all channels, EDGE_CAP=0 everywhere, irq stays 0 for 20 cycles.
- Set/clear: write OUT ch2=16'h1234, OUTSET ch2=16'h000F, OUTCLR ch2=16'h1000 -> pio_out ch2 = 16'h023F; read OUT ch2 returns 32'h0000023F one cycle after avs_read.
- Rising edge with IRQ: EDGE_MODE=0, MASK ch1=16'h0001, toggle pio_in ch1 bit0 0->1 -> EDGE_CAP ch1 = 1 after SYNC_STAGES+1 cycles, irq=1 one cycle later. A falling edge on the same bit causes no new capture.
- W1C collision: with EDGE_CAP ch0 bit3 set, write EDGE_CAP ch0=16'h0008 in the same cycle a new edge arrives on bit3 -> bit3 remains 1. A separate W1C to bit5 only clears bit5.
- Unmapped access: read offset 6 of ch0 and channel index NUM_CH -> readdata 0; write 32'hFFFFFFFF to each -> no register changes. Read IN ch3 with pio_in ch3=16'hA5A5 stable -> 32'h0000A5A5.
- Any-edge mode: EDGE_MODE=2, drive pio_in ch0 = 16'h0000 -> 16'h0101 -> 16'h0001 -> EDGE_CAP ch0 = 16'h0101. Mask 0 on all channels -> irq remains 0.
